// File: rtl/lsu_align.sv
// RV32I MEM-stage load/store unit: one word-aligned req/ack access per start,
// with store lane steering and load byte/half extraction and extension.
module lsu_align #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              fault,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_is_store;
    logic [2:0]          r_funct3;
    logic [1:0]          r_lane;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [3:0]          r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_load_data;
    logic                r_done;
    logic                r_fault;
    logic                r_busy;

    state_t              w_state_next;
    logic                w_is_store_next;
    logic [2:0]          w_funct3_next;
    logic [1:0]          w_lane_next;
    logic                w_mem_req_next;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic [3:0]          w_mem_we_next;
    logic [DATA_W-1:0]   w_mem_wdata_next;
    logic [DATA_W-1:0]   w_load_data_next;
    logic                w_done_next;
    logic                w_fault_next;

    logic                w_legal;
    logic                w_misaligned;
    logic [3:0]          w_st_we;
    logic [DATA_W-1:0]   w_st_wdata;
    logic [7:0]          w_rd_byte [4];
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [DATA_W-1:0]   w_ld_ext;

    // Request decode: funct3 legality depends on direction (no LBU/LHU-style stores).
    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = !is_store;
            default:                w_legal = 1'b0;
        endcase
        w_misaligned = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            w_misaligned = addr[0];
        end else if (funct3[1:0] == 2'b10) begin
            w_misaligned = (addr[1:0] != 2'b00);
        end
    end

    always_comb begin
        w_st_we    = 4'b1111;
        w_st_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                w_st_we    = 4'b0001 << addr[1:0];
                w_st_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_st_we    = addr[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_st_we    = 4'b1111;
                w_st_wdata = store_data;
            end
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign w_rd_byte[gi] = mem_rdata[gi*8 +: 8];
    end

    assign w_byte = w_rd_byte[r_lane];
    assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_ext = {24'd0, w_byte};
            3'b101:  w_ld_ext = {16'd0, w_half};
            default: w_ld_ext = mem_rdata;
        endcase
    end

    // Next-state and registered-output logic; every output is a flop.
    always_comb begin
        w_state_next     = r_state;
        w_is_store_next  = r_is_store;
        w_funct3_next    = r_funct3;
        w_lane_next      = r_lane;
        w_mem_req_next   = r_mem_req;
        w_mem_addr_next  = r_mem_addr;
        w_mem_we_next    = r_mem_we;
        w_mem_wdata_next = r_mem_wdata;
        w_load_data_next = r_load_data;
        w_done_next      = 1'b0;
        w_fault_next     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_legal && !w_misaligned) begin
                        w_is_store_next = is_store;
                        w_funct3_next   = funct3;
                        w_lane_next     = addr[1:0];
                        w_mem_addr_next = {addr[ADDR_W-1:2], 2'b00};
                        w_mem_we_next   = is_store ? w_st_we : 4'b0000;
                        if (is_store) begin
                            w_mem_wdata_next = w_st_wdata;
                        end
                        w_mem_req_next  = 1'b1;
                        w_state_next    = S_ACCESS;
                    end else begin
                        w_state_next = S_FAULT;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    w_mem_req_next = 1'b0;
                    w_mem_we_next  = 4'b0000;
                    if (!r_is_store) begin
                        w_load_data_next = w_ld_ext;
                    end
                    w_done_next  = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            S_FAULT: begin
                w_done_next  = 1'b1;
                w_fault_next = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= 3'd0;
            r_lane      <= 2'd0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 4'd0;
            r_mem_wdata <= '0;
            r_load_data <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_is_store  <= w_is_store_next;
            r_funct3    <= w_funct3_next;
            r_lane      <= w_lane_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_load_data <= w_load_data_next;
            r_done      <= w_done_next;
            r_fault     <= w_fault_next;
            r_busy      <= (w_state_next != S_IDLE);
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign load_data = r_load_data;
    assign done      = r_done;
    assign fault     = r_fault;
    assign busy      = r_busy;

endmodule

// File: tb/tb_lsu_align.sv
// Directed-vector bench for lsu_align: stimulus pushes expected requests and
// completions into queues, a negedge monitor pops and compares them.
module tb_lsu_align;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        fault;
    logic        busy;

    lsu_align #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .load_data  (load_data),
        .done       (done),
        .fault      (fault),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        int          hold;
    } req_t;

    typedef struct {
        logic        f;
        logic [31:0] ld;
        int          lat;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;
    int op_num      = 0;

    req_t  cur_req;
    bit    in_req   = 0;
    int    hold_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: request fields/stability/hold length and completion results.
    always @(negedge clk) begin
        done_t d;
        if (rst) begin
            in_req   = 0;
            hold_cnt = 0;
        end else begin
            if (mem_req) begin
                if (!in_req) begin
                    chk("req_queue_nonempty", (req_q.size() != 0), 1);
                    if (req_q.size() != 0) begin
                        cur_req = req_q.pop_front();
                        chk("req_addr", mem_addr, cur_req.addr);
                        chk("req_we", {28'd0, mem_we}, {28'd0, cur_req.we});
                        chk("req_wdata", mem_wdata, cur_req.wdata);
                    end
                    in_req   = 1;
                    hold_cnt = 1;
                end else begin
                    hold_cnt++;
                    chk("req_addr_stable", mem_addr, cur_req.addr);
                    chk("req_we_stable", {28'd0, mem_we}, {28'd0, cur_req.we});
                    chk("req_wdata_stable", mem_wdata, cur_req.wdata);
                end
            end else if (in_req) begin
                in_req = 0;
                chk("req_hold_cycles", hold_cnt, cur_req.hold);
                chk("we_cleared", {28'd0, mem_we}, 32'd0);
            end
            if (done) begin
                chk("done_queue_nonempty", (done_q.size() != 0), 1);
                if (done_q.size() != 0) begin
                    d = done_q.pop_front();
                    op_num++;
                    $display("op %0d: fault=%0d load_data=0x%08h latency=%0d",
                             op_num, fault, load_data, cyc - start_cyc);
                    chk("fault", {31'd0, fault}, {31'd0, d.f});
                    chk("load_data", load_data, d.ld);
                    chk("latency", cyc - start_cyc, d.lat);
                end
            end
        end
    end

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rd, input int waits,
                          input logic exp_f, input logic [31:0] exp_ma, input logic [3:0] exp_we,
                          input logic [31:0] exp_wd, input logic [31:0] exp_ld,
                          input bit pulse_busy);
        req_t  r;
        done_t d;
        bit    seen;
        if (!exp_f) begin
            r.addr  = exp_ma;
            r.we    = exp_we;
            r.wdata = exp_wd;
            r.hold  = waits + 1;
            req_q.push_back(r);
        end
        d.f   = exp_f;
        d.ld  = exp_ld;
        d.lat = exp_f ? 1 : waits + 1;
        done_q.push_back(d);

        start      = 1'b1;
        is_store   = st;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        @(posedge clk); #1;
        start_cyc = cyc;
        start     = 1'b0;
        if (!exp_f) begin
            for (int i = 0; i < waits; i++) begin
                @(posedge clk); #1;
                start    = pulse_busy && (i + 1 < waits);
                is_store = 1'b0;
                funct3   = 3'b010;
                addr     = 32'h0000_0080;
            end
            start     = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = rd;
            @(posedge clk); #1;
            mem_ack   = 1'b0;
        end
        seen = 0;
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        req_t r;
        rst        = 1'b1;
        start      = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'd0;
        store_data = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        //     st    f3      addr          sd            rdata         w  flt  mem_addr      we       wdata         load_data    pulse
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80, 0);
        run_op(1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00FF, 0);
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,        32'h0000_BEEF, 0);
        run_op(1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,        32'hFFFF_BEEF, 0);
        run_op(1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 32'h0,        0, 1'b0, 32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_BEEF, 0);
        run_op(1'b1, 3'b001, 32'h0000_0012, 32'h0000_1234, 32'h0,        0, 1'b0, 32'h0000_0010, 4'b1100, 32'h1234_1234, 32'hFFFF_BEEF, 0);
        run_op(1'b1, 3'b010, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,        3, 1'b0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_BEEF, 1);
        run_op(1'b0, 3'b010, 32'h0000_0041, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_BEEF, 0);
        run_op(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_BEEF, 0);
        run_op(1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_BEEF, 0);
        run_op(1'b0, 3'b001, 32'h0000_2001, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'hFFFF_BEEF, 0);

        // Reset while waiting for ack, followed by a stray ack.
        r.addr  = 32'h0000_0004;
        r.we    = 4'b0000;
        r.wdata = 32'hDEAD_BEEF;
        r.hold  = 0;
        req_q.push_back(r);
        start    = 1'b1;
        is_store = 1'b0;
        funct3   = 3'b010;
        addr     = 32'h0000_0004;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_load_data", load_data, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_ack_no_done", {31'd0, done}, 32'd0);
            chk("stray_ack_no_req", {31'd0, mem_req}, 32'd0);
            chk("stray_ack_load_data", load_data, 32'd0);
        end
        @(posedge clk); #1;

        run_op(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hCAFE_BABE, 0, 1'b0, 32'h0000_0000, 4'b0000, 32'h0, 32'hCAFE_BABE, 0);

        repeat (3) @(posedge clk);
        chk("req_queue_drained", req_q.size(), 32'd0);
        chk("done_queue_drained", done_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Multi-cycle load/store unit for the RV32I core, in the MEM stage.
- Takes the effective address from the ALU and the rs2 store data, and performs one word-aligned data-memory access with a req/ack handshake.
- For stores it drives byte enables and lane-replicated write data.
- For loads it extracts and sign/zero-extends the addressed byte/half/word into load_data. load_data is the memory-side input of the 2:1 writeback select mux; the other input is the ALU result.

Parameters:
- ADDR_W, 32, byte-address width of addr and mem_addr.
- DATA_W, 32, data width. Fixed at 32; other values unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load; sampled with start
- funct3  in  3  RV32I width/sign code; sampled with start
- addr  in  ADDR_W  effective byte address; sampled with start
- store_data  in  32  rs2 value; sampled with start
- mem_req  out  1  memory request; held until ack
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_we  out  4  byte write enables; 0000 for loads
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory completion; rdata valid in the same cycle
- mem_rdata  in  32  read word
- load_data  out  32  extended load result; held until the next completed load
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: misaligned access or illegal funct3
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: mem_req=0, mem_addr=0, mem_we=0, mem_wdata=0, load_data=0, done=0, fault=0, busy=0, state=IDLE.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misalignment rules: a halfword access with addr[0]=1 is misaligned; a word access with addr[1:0]!=00 is misaligned.
- State machine: IDLE, ACCESS, DONE, FAULT.
- IDLE, start=1, access legal and aligned:
  - Latch is_store, funct3 and addr[1:0].
  - Drive mem_addr.
  - For stores: mem_we = SB 0001<<addr[1:0]; SH 0011 if addr[1]=0 else 1100; SW 1111.
  - mem_wdata = SB {4{sd[7:0]}}; SH {2{sd[15:0]}}; SW sd.
  - Set mem_req=1 and go to ACCESS.
- IDLE, start=1, access illegal or misaligned: go to FAULT. No mem_req is issued.
- ACCESS: mem_req stays high and mem_addr/mem_we/mem_wdata stay stable until mem_ack=1 is sampled. Then:
  - mem_req=0, mem_we=0.
  - For loads, load_data is captured from the byte lane addr[1:0] (half lane addr[1]). LB/LH sign-extend; LBU/LHU zero-extend. Stores leave load_data unchanged.
  - Go to DONE.
- DONE: done=1, fault=0 for exactly one cycle, then IDLE.
- FAULT: done=1, fault=1 for one cycle, then IDLE. load_data and all memory outputs are unchanged.
- Latency:
  - start at edge N gives mem_req high after edge N+1.
  - With ack in the first req cycle, done is high after edge N+2.
  - Each wait cycle adds 1.
  - Fault path: done after edge N+2.
- start while busy=1 is ignored; no queueing.
- start is accepted in the cycle right after done, giving back-to-back operation.
- mem_ack outside ACCESS is ignored.
- rst asserted mid-ACCESS: all outputs return to reset values at that edge and mem_req drops. Any late mem_ack is ignored.

Test Plan:
- LB at addr 0x00000103, mem_rdata 0x80FF7F01, ack in first req cycle -> mem_addr 0x00000100, mem_we 0000, load_data 0xFFFFFF80, done after edge N+2, fault=0.
- LHU at addr 0x2002, rdata 0xBEEF1234 -> load_data 0x0000BEEF. Then LH at the same address -> 0xFFFFBEEF.
- SB at addr 0x11, store_data 0x000000A5 -> mem_addr 0x10, mem_we 0010, mem_wdata 0xA5A5A5A5. SH at 0x12, sd 0x1234 -> mem_we 1100, mem_wdata 0x12341234.
- SW at addr 0x40, mem_ack held low 3 cycles -> mem_req and outputs stable for 4 cycles, done one cycle after ack, start pulses during busy ignored.
- LW at 0x41 -> fault=1 with done after edge N+2, mem_req never asserts, load_data unchanged. funct3=011 load -> same fault.
- rst during ACCESS wait, then a stray mem_ack -> all outputs 0, state IDLE, no done pulse. A following LW at 0x0, rdata 0xCAFEBABE -> load_data 0xCAFEBABE.
